// File: rtl/reg_mux_pkg.sv
// Shared constants and helpers for the registered channel selector.
package reg_mux_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Ceiling log2, floored at 1 so that index/counter vectors never collapse to zero width.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_next_pick.sv
// Circular next-set-bit search: first mask bit set at cur+1 .. cur+NCH (mod NCH).
// Returns cur itself when it is the only set bit; any reports a non-empty mask.
module rr_next_pick
    import reg_mux_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int SELW = clog2(NCH)
) (
    input  logic [NCH-1:0]  mask,
    input  logic [SELW-1:0] cur,
    output logic [SELW-1:0] nxt,
    output logic            any
);

    // Walk forward from the current channel and keep the first enabled one.
    always_comb begin
        logic found;
        int   idx;
        nxt   = cur;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(cur) + k) % NCH;
            if (!found && mask[idx]) begin
                nxt   = SELW'(idx);
                found = 1'b1;
            end
        end
        any = |mask;
    end

endmodule

// File: rtl/reg_mux_scan.sv
// Registered NCH:1 selector with host-driven DIRECT mode and a masked
// round-robin SCAN mode that dwells DWELL enabled cycles on each channel.
module reg_mux_scan
    import reg_mux_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int W     = 8,
    parameter  int DWELL = 1,
    localparam int SELW  = clog2(NCH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic [NCH-1:0]    ch_mask,
    input  logic [NCH*W-1:0]  in_bus,
    output logic [W-1:0]      d_next,
    output logic [W-1:0]      out,
    output logic [SELW-1:0]   out_ch,
    output logic              out_valid
);

    localparam int              DW_W       = clog2(DWELL + 1);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    logic [W-1:0]    out_q,       out_d;
    logic [SELW-1:0] out_ch_q,    out_ch_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] ptr_q,       ptr_d;
    logic [DW_W-1:0] dwell_q,     dwell_d;
    logic            last_mode_q, last_mode_d;

    logic [SELW-1:0] src;
    logic            src_ok;
    logic            ptr_on;
    logic [SELW-1:0] nxt;
    logic            any_en;

    rr_next_pick #(
        .NCH (NCH)
    ) u_pick (
        .mask (ch_mask),
        .cur  (ptr_q),
        .nxt  (nxt),
        .any  (any_en)
    );

    // Source index and unregistered mux; an index beyond the last channel yields zero.
    always_comb begin
        src    = (mode == MODE_SCAN) ? ptr_q : sel;
        d_next = '0;
        src_ok = 1'b0;
        ptr_on = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (src == SELW'(i)) begin
                d_next = in_bus[i*W +: W];
                src_ok = 1'b1;
            end
            if (ptr_q == SELW'(i) && ch_mask[i]) ptr_on = 1'b1;
        end
    end

    // Next-state for output register, pointer and dwell counter.
    always_comb begin
        logic            mode_chg;
        logic [DW_W-1:0] dwell_eff;
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        dwell_d     = dwell_q;
        last_mode_d = last_mode_q;
        // A mode switch restarts the dwell; this edge counts as the first of the new dwell.
        mode_chg    = (mode != last_mode_q);
        dwell_eff   = mode_chg ? '0 : dwell_q;
        if (en) begin
            last_mode_d = mode;
            if (mode == MODE_DIRECT) begin
                if (mode_chg) dwell_d = '0;
                if (src_ok) begin
                    out_d       = d_next;
                    out_ch_d    = sel;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else begin
                if (!any_en) begin
                    out_valid_d = 1'b0;
                    dwell_d     = '0;
                end else if (!ptr_on) begin
                    // Mask was pulled from under the pointer: skip without sampling.
                    out_valid_d = 1'b0;
                    ptr_d       = nxt;
                    dwell_d     = '0;
                end else begin
                    out_d       = d_next;
                    out_ch_d    = ptr_q;
                    out_valid_d = 1'b1;
                    if (dwell_eff == DWELL_LAST) begin
                        ptr_d   = nxt;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_eff + DW_W'(1);
                    end
                end
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
            dwell_q     <= '0;
            last_mode_q <= MODE_DIRECT;
        end else begin
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
            dwell_q     <= dwell_d;
            last_mode_q <= last_mode_d;
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_reg_mux_scan.sv
// Directed bench for reg_mux_scan: three instances cover NCH=4/DWELL=1,
// NCH=3/DWELL=1 and NCH=4/DWELL=2.
module tb_reg_mux_scan;

    logic        clk = 1'b0;
    logic        reset_n, en, mode;
    logic [1:0]  sel4, sel3;
    logic [3:0]  mask4;
    logic [2:0]  mask3;
    logic [31:0] bus4;
    logic [23:0] bus3;

    logic [7:0]  dn_a, out_a, dn_b, out_b, dn_c, out_c;
    logic [1:0]  ch_a, ch_b, ch_c;
    logic        v_a, v_b, v_c;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_ch3  [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0};
    logic [7:0] exp_out3 [8] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h44, 8'h44, 8'h11, 8'h11};

    always #5 clk = ~clk;

    reg_mux_scan #(.NCH(4), .W(8), .DWELL(1)) u_a (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .sel(sel4),
        .ch_mask(mask4), .in_bus(bus4), .d_next(dn_a), .out(out_a),
        .out_ch(ch_a), .out_valid(v_a)
    );

    reg_mux_scan #(.NCH(3), .W(8), .DWELL(1)) u_b (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .sel(sel3),
        .ch_mask(mask3), .in_bus(bus3), .d_next(dn_b), .out(out_b),
        .out_ch(ch_b), .out_valid(v_b)
    );

    reg_mux_scan #(.NCH(4), .W(8), .DWELL(2)) u_c (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .sel(sel4),
        .ch_mask(mask4), .in_bus(bus4), .d_next(dn_c), .out(out_c),
        .out_ch(ch_c), .out_valid(v_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b1; mode = 1'b1; mask4 = 4'hF;
        step(); step();
        checks++; if (out_a !== 8'h00) begin errors++; $display("FAIL reset_out_a got %h exp 00", out_a); end
        checks++; if (ch_a !== 2'd0) begin errors++; $display("FAIL reset_ch_a got %0d exp 0", ch_a); end
        checks++; if (v_a !== 1'b0) begin errors++; $display("FAIL reset_valid_a got %b exp 0", v_a); end
        checks++; if (v_c !== 1'b0) begin errors++; $display("FAIL reset_valid_c got %b exp 0", v_c); end
        checks++; if (out_b !== 8'h00) begin errors++; $display("FAIL reset_out_b got %h exp 00", out_b); end
        reset_n = 1'b1;
    endtask

    task automatic test_direct();
        do_reset();
        mode = 1'b0; en = 1'b1; sel4 = 2'd2;
        #1;
        checks++; if (dn_a !== 8'h33) begin errors++; $display("FAIL direct_dnext got %h exp 33", dn_a); end
        step();
        checks++; if (out_a !== 8'h33) begin errors++; $display("FAIL direct_out got %h exp 33", out_a); end
        checks++; if (ch_a !== 2'd2) begin errors++; $display("FAIL direct_ch got %0d exp 2", ch_a); end
        checks++; if (v_a !== 1'b1) begin errors++; $display("FAIL direct_valid got %b exp 1", v_a); end
        sel4 = 2'd0;
        step();
        checks++; if (out_a !== 8'h11) begin errors++; $display("FAIL direct_out0 got %h exp 11", out_a); end
        checks++; if (ch_a !== 2'd0) begin errors++; $display("FAIL direct_ch0 got %0d exp 0", ch_a); end
        en = 1'b0; sel4 = 2'd3;
        #1;
        checks++; if (dn_a !== 8'h44) begin errors++; $display("FAIL direct_dnext3 got %h exp 44", dn_a); end
        step();
        checks++; if (out_a !== 8'h11) begin errors++; $display("FAIL direct_hold_out got %h exp 11", out_a); end
        checks++; if (v_a !== 1'b1) begin errors++; $display("FAIL direct_hold_valid got %b exp 1", v_a); end
    endtask

    task automatic test_out_of_range();
        mode = 1'b0; en = 1'b1; sel3 = 2'd1;
        step();
        checks++; if (out_b !== 8'h22) begin errors++; $display("FAIL oor_pre_out got %h exp 22", out_b); end
        checks++; if (v_b !== 1'b1) begin errors++; $display("FAIL oor_pre_valid got %b exp 1", v_b); end
        sel3 = 2'd3;
        #1;
        checks++; if (dn_b !== 8'h00) begin errors++; $display("FAIL oor_dnext got %h exp 00", dn_b); end
        step();
        checks++; if (out_b !== 8'h22) begin errors++; $display("FAIL oor_out got %h exp 22", out_b); end
        checks++; if (v_b !== 1'b0) begin errors++; $display("FAIL oor_valid got %b exp 0", v_b); end
        checks++; if (ch_b !== 2'd1) begin errors++; $display("FAIL oor_ch got %0d exp 1", ch_b); end
    endtask

    task automatic test_scan_dwell2();
        do_reset();
        mode = 1'b1; mask4 = 4'b1011; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (ch_c !== exp_ch3[i]) begin errors++; $display("FAIL dwell2_ch[%0d] got %0d exp %0d", i, ch_c, exp_ch3[i]); end
            checks++; if (out_c !== exp_out3[i]) begin errors++; $display("FAIL dwell2_out[%0d] got %h exp %h", i, out_c, exp_out3[i]); end
            checks++; if (v_c !== 1'b1) begin errors++; $display("FAIL dwell2_valid[%0d] got %b exp 1", i, v_c); end
        end
    endtask

    task automatic test_freeze_mask();
        do_reset();
        mode = 1'b1; mask4 = 4'hF; en = 1'b1;
        step(); step();
        checks++; if (out_a !== 8'h22) begin errors++; $display("FAIL frz_pre_out got %h exp 22", out_a); end
        checks++; if (ch_a !== 2'd1) begin errors++; $display("FAIL frz_pre_ch got %0d exp 1", ch_a); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_a !== 8'h22) begin errors++; $display("FAIL frz_out[%0d] got %h exp 22", i, out_a); end
            checks++; if (ch_a !== 2'd1) begin errors++; $display("FAIL frz_ch[%0d] got %0d exp 1", i, ch_a); end
            checks++; if (v_a !== 1'b1) begin errors++; $display("FAIL frz_valid[%0d] got %b exp 1", i, v_a); end
            checks++; if (dn_a !== 8'h33) begin errors++; $display("FAIL frz_ptr[%0d] got %h exp 33", i, dn_a); end
        end
        en = 1'b1;
        step();
        checks++; if (out_a !== 8'h33) begin errors++; $display("FAIL frz_resume_out got %h exp 33", out_a); end
        checks++; if (ch_a !== 2'd2) begin errors++; $display("FAIL frz_resume_ch got %0d exp 2", ch_a); end
        mask4 = 4'b0000;
        step();
        checks++; if (v_a !== 1'b0) begin errors++; $display("FAIL mask0_valid got %b exp 0", v_a); end
        checks++; if (out_a !== 8'h33) begin errors++; $display("FAIL mask0_out got %h exp 33", out_a); end
        checks++; if (dn_a !== 8'h44) begin errors++; $display("FAIL mask0_ptr got %h exp 44", dn_a); end
        mask4 = 4'b0100;
        step();
        checks++; if (v_a !== 1'b0) begin errors++; $display("FAIL mask4_skip_valid got %b exp 0", v_a); end
        checks++; if (out_a !== 8'h33) begin errors++; $display("FAIL mask4_skip_out got %h exp 33", out_a); end
        checks++; if (dn_a !== 8'h33) begin errors++; $display("FAIL mask4_ptr got %h exp 33", dn_a); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (ch_a !== 2'd2) begin errors++; $display("FAIL single_ch[%0d] got %0d exp 2", i, ch_a); end
            checks++; if (v_a !== 1'b1) begin errors++; $display("FAIL single_valid[%0d] got %b exp 1", i, v_a); end
            checks++; if (out_a !== 8'h33) begin errors++; $display("FAIL single_out[%0d] got %h exp 33", i, out_a); end
        end
    endtask

    task automatic test_reset_midscan();
        do_reset();
        mode = 1'b1; mask4 = 4'hF; en = 1'b1;
        repeat (7) step();
        checks++; if (ch_c !== 2'd3) begin errors++; $display("FAIL midrst_pre_ch got %0d exp 3", ch_c); end
        checks++; if (out_c !== 8'h44) begin errors++; $display("FAIL midrst_pre_out got %h exp 44", out_c); end
        reset_n = 1'b0;
        step();
        checks++; if (out_c !== 8'h00) begin errors++; $display("FAIL midrst_out got %h exp 00", out_c); end
        checks++; if (ch_c !== 2'd0) begin errors++; $display("FAIL midrst_ch got %0d exp 0", ch_c); end
        checks++; if (v_c !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", v_c); end
        reset_n = 1'b1;
        step();
        checks++; if (out_c !== 8'h11) begin errors++; $display("FAIL midrst_post_out got %h exp 11", out_c); end
        checks++; if (ch_c !== 2'd0) begin errors++; $display("FAIL midrst_post_ch got %0d exp 0", ch_c); end
        checks++; if (v_c !== 1'b1) begin errors++; $display("FAIL midrst_post_valid got %b exp 1", v_c); end
    endtask

    task automatic test_mask_mid_dwell();
        mask4 = 4'b1110;
        step();
        checks++; if (v_c !== 1'b0) begin errors++; $display("FAIL middwell_valid got %b exp 0", v_c); end
        checks++; if (out_c !== 8'h11) begin errors++; $display("FAIL middwell_out got %h exp 11", out_c); end
        checks++; if (ch_c !== 2'd0) begin errors++; $display("FAIL middwell_ch got %0d exp 0", ch_c); end
        step();
        checks++; if (ch_c !== 2'd1) begin errors++; $display("FAIL middwell_j1_ch got %0d exp 1", ch_c); end
        checks++; if (out_c !== 8'h22) begin errors++; $display("FAIL middwell_j1_out got %h exp 22", out_c); end
        step();
        checks++; if (ch_c !== 2'd1) begin errors++; $display("FAIL middwell_j2_ch got %0d exp 1", ch_c); end
        step();
        checks++; if (ch_c !== 2'd2) begin errors++; $display("FAIL middwell_j3_ch got %0d exp 2", ch_c); end
        checks++; if (out_c !== 8'h33) begin errors++; $display("FAIL middwell_j3_out got %h exp 33", out_c); end
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; mode = 1'b0;
        sel4 = '0; sel3 = '0; mask4 = '0; mask3 = '0;
        bus4 = 32'h44332211;
        bus3 = 24'h332211;
        test_reset();
        test_direct();
        test_out_of_range();
        test_scan_dwell2();
        test_freeze_mask();
        test_reset_midscan();
        test_mask_mid_dwell();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
